cache_data_array: RTL and testbench

Set-associative data storage for the unified cache: holds one cache block per (set, way) and supports a synchronous block write to one or more ways and a combinational block read from one way. It sits beside the tag array in the unified cache. The cache controller supplies the set index and a way-select vector derived from tag lookup or replacement. The module is named `cache_data_array`; its instance in the cache is `data_array`.

---
 rtl/cache_data_array_pkg.sv | 9 +
 rtl/cache_data_array_way.sv | 52 +++++
 rtl/cache_data_array.sv | 62 ++++++
 tb/tb_cache_data_array.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/cache_data_array_pkg.sv
// Shared cache constants: default data-array geometry and the derived set-pointer width.
package cache_data_array_pkg;

    localparam int DEFAULT_BLOCK_SIZE_IN_BITS = 64;
    localparam int DEFAULT_NUMBER_SETS        = 64;
    localparam int DEFAULT_NUMBER_WAYS        = 16;
    localparam int DEFAULT_SET_PTR_WIDTH      = $clog2(DEFAULT_NUMBER_SETS);

endpackage : cache_data_array_pkg

// File: rtl/cache_data_array_way.sv
// One way of the cache data array: NUMBER_SETS blocks, synchronous write/clear, asynchronous read.
module data_array_way
    import cache_data_array_pkg::*;
#(
    parameter int CACHE_BLOCK_SIZE_IN_BITS = DEFAULT_BLOCK_SIZE_IN_BITS,
    parameter int NUMBER_SETS              = DEFAULT_NUMBER_SETS,
    parameter int SET_PTR_WIDTH_IN_BITS    = $clog2(NUMBER_SETS)
) (
    input  logic                                clk_in,
    input  logic                                reset_in,
    input  logic                                write_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]    set_addr_in,
    input  logic [CACHE_BLOCK_SIZE_IN_BITS-1:0] write_data_in,
    output logic [CACHE_BLOCK_SIZE_IN_BITS-1:0] read_data_out
);

    // One extra bit so a power-of-two set count does not wrap to zero.
    localparam logic [SET_PTR_WIDTH_IN_BITS:0] SET_LIMIT = (SET_PTR_WIDTH_IN_BITS + 1)'(NUMBER_SETS);

    logic [CACHE_BLOCK_SIZE_IN_BITS-1:0] mem_r [NUMBER_SETS];
    logic                                addr_in_range_s;
    logic [CACHE_BLOCK_SIZE_IN_BITS-1:0] read_data_s;

    // Set index validity check for non-power-of-two set counts.
    always_comb begin
        addr_in_range_s = ({1'b0, set_addr_in} < SET_LIMIT);
    end

    // Block storage: reset clears every set and wins over a write in the same cycle.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            for (int s = 0; s < NUMBER_SETS; s++) begin
                mem_r[s] <= '0;
            end
        end else if (write_en_in && addr_in_range_s) begin
            mem_r[set_addr_in] <= write_data_in;
        end
    end

    // Asynchronous read port; out-of-range sets read as zero.
    always_comb begin
        read_data_s = '0;
        if (addr_in_range_s) begin
            read_data_s = mem_r[set_addr_in];
        end else begin
            read_data_s = '0;
        end
    end

    assign read_data_out = read_data_s;

endmodule : data_array_way

// File: rtl/cache_data_array.sv
// Set-associative cache data storage: multi-way block write and lowest-index priority block read.
module cache_data_array
    import cache_data_array_pkg::*;
#(
    parameter int CACHE_BLOCK_SIZE_IN_BITS = DEFAULT_BLOCK_SIZE_IN_BITS,
    parameter int NUMBER_SETS              = DEFAULT_NUMBER_SETS,
    parameter int NUMBER_WAYS              = DEFAULT_NUMBER_WAYS,
    parameter int SET_PTR_WIDTH_IN_BITS    = $clog2(NUMBER_SETS)
) (
    input  logic                                clk_in,
    input  logic                                reset_in,
    input  logic                                access_en_in,
    input  logic                                write_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]    access_set_addr_in,
    input  logic [NUMBER_WAYS-1:0]              way_select_in,
    input  logic [CACHE_BLOCK_SIZE_IN_BITS-1:0] write_data_in,
    output logic [CACHE_BLOCK_SIZE_IN_BITS-1:0] read_data_out
);

    logic [NUMBER_WAYS-1:0]              way_write_en_s;
    logic [CACHE_BLOCK_SIZE_IN_BITS-1:0] way_data_s [NUMBER_WAYS];
    logic [CACHE_BLOCK_SIZE_IN_BITS-1:0] read_data_s;

    // Per-way write enable decode.
    always_comb begin
        way_write_en_s = way_select_in & {NUMBER_WAYS{access_en_in & write_en_in}};
    end

    for (genvar w = 0; w < NUMBER_WAYS; w++) begin : g_way
        data_array_way #(
            .CACHE_BLOCK_SIZE_IN_BITS (CACHE_BLOCK_SIZE_IN_BITS),
            .NUMBER_SETS              (NUMBER_SETS),
            .SET_PTR_WIDTH_IN_BITS    (SET_PTR_WIDTH_IN_BITS)
        ) u_way (
            .clk_in        (clk_in),
            .reset_in      (reset_in),
            .write_en_in   (way_write_en_s[w]),
            .set_addr_in   (access_set_addr_in),
            .write_data_in (write_data_in),
            .read_data_out (way_data_s[w])
        );
    end

    // Priority read mux: scanning from the top down leaves the lowest selected way in place.
    always_comb begin
        read_data_s = '0;
        if (access_en_in) begin
            for (int w = NUMBER_WAYS - 1; w >= 0; w--) begin
                if (way_select_in[w]) begin
                    read_data_s = way_data_s[w];
                end else begin
                    read_data_s = read_data_s;
                end
            end
        end else begin
            read_data_s = '0;
        end
    end

    assign read_data_out = read_data_s;

endmodule : cache_data_array

// File: tb/tb_cache_data_array.sv
// Scoreboard bench for cache_data_array: directed scenarios followed by randomized traffic.
module tb_cache_data_array;

    localparam int BB = 64;
    localparam int NS = 64;
    localparam int NW = 16;

    logic          clk_in = 1'b0;
    logic          reset_in;
    logic          access_en_in;
    logic          write_en_in;
    logic [5:0]    access_set_addr_in;
    logic [NW-1:0] way_select_in;
    logic [BB-1:0] write_data_in;
    logic [BB-1:0] read_data_out;

    cache_data_array dut (
        .clk_in             (clk_in),
        .reset_in           (reset_in),
        .access_en_in       (access_en_in),
        .write_en_in        (write_en_in),
        .access_set_addr_in (access_set_addr_in),
        .way_select_in      (way_select_in),
        .write_data_in      (write_data_in),
        .read_data_out      (read_data_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [BB-1:0] exp;
        string         name;
    } exp_t;

    exp_t          sb_q[$];
    logic [BB-1:0] model [NS][NW];
    int            checks = 0;
    int            errors = 0;

    // Reference read: the lowest-numbered selected way of the set, zero when idle.
    function automatic logic [BB-1:0] model_read(input logic en, input int set, input logic [NW-1:0] mask);
        if (!en || mask == '0) return '0;
        for (int w = 0; w < NW; w++)
            if (mask[w]) return model[set][w];
        return '0;
    endfunction

    // One cycle of stimulus; inputs change just after a rising edge.
    task automatic drive(input logic rst, input logic en, input logic we, input int set,
                         input logic [NW-1:0] mask, input logic [BB-1:0] data,
                         input logic chk, input string name);
        exp_t e;
        reset_in           = rst;
        access_en_in       = en;
        write_en_in        = we;
        access_set_addr_in = 6'(set);
        way_select_in      = mask;
        write_data_in      = data;
        if (chk) begin
            e.exp  = model_read(en, set, mask);
            e.name = name;
            sb_q.push_back(e);
        end
        @(posedge clk_in);
        if (rst) begin
            for (int s = 0; s < NS; s++)
                for (int w = 0; w < NW; w++)
                    model[s][w] = '0;
        end else if (en && we) begin
            for (int w = 0; w < NW; w++)
                if (mask[w]) model[set][w] = data;
        end
        #1;
    endtask

    // Monitor: the output is valid every cycle, compared mid-cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (read_data_out !== e.exp) begin
                    errors++;
                    $display("FAIL %s: read_data_out=%h expected=%h", e.name, read_data_out, e.exp);
                end
            end
        end
    end

    initial begin
        logic [NW-1:0] m;
        int            s;
        for (int a = 0; a < NS; a++)
            for (int w = 0; w < NW; w++)
                model[a][w] = '0;
        reset_in = 1'b0; access_en_in = 1'b0; write_en_in = 1'b0;
        access_set_addr_in = 6'd0; way_select_in = 16'h0000; write_data_in = 64'h0;
        @(posedge clk_in); #1;

        // Reset
        drive(1'b1, 1'b0, 1'b0, 0, 16'h0000, 64'h0, 1'b0, "reset");
        drive(1'b0, 1'b1, 1'b0, 0,  16'h0001, 64'h0, 1'b1, "reset_set0");
        drive(1'b0, 1'b1, 1'b0, 63, 16'h0001, 64'h0, 1'b1, "reset_set63");

        // Basic write-read: pre-edge shows old contents, then the new block in every way
        drive(1'b0, 1'b1, 1'b1, 63, 16'hFFFF, 64'hFFFF_FFFF_0000_0000, 1'b1, "write_pre_edge");
        drive(1'b0, 1'b1, 1'b0, 63, 16'hFFFF, 64'h0, 1'b1, "basic_ffff");
        drive(1'b0, 1'b1, 1'b0, 63, 16'h8000, 64'h0, 1'b1, "basic_8000");
        drive(1'b0, 1'b1, 1'b0, 63, 16'h0001, 64'h0, 1'b1, "basic_0001");

        // Way isolation and priority
        drive(1'b0, 1'b1, 1'b1, 5, 16'h0004, 64'hA5A5, 1'b1, "iso_wr1");
        drive(1'b0, 1'b1, 1'b1, 5, 16'h0010, 64'h5A5A, 1'b1, "iso_wr2");
        drive(1'b0, 1'b1, 1'b0, 5, 16'h0004, 64'h0, 1'b1, "iso_way2");
        drive(1'b0, 1'b1, 1'b0, 5, 16'h0010, 64'h0, 1'b1, "iso_way4");
        drive(1'b0, 1'b1, 1'b0, 5, 16'h0001, 64'h0, 1'b1, "iso_way0");
        drive(1'b0, 1'b1, 1'b0, 6, 16'h0004, 64'h0, 1'b1, "iso_set6");
        drive(1'b0, 1'b1, 1'b0, 5, 16'h0014, 64'h0, 1'b1, "priority_0014");
        drive(1'b0, 1'b1, 1'b0, 5, 16'h0000, 64'h0, 1'b1, "mask_zero");
        drive(1'b0, 1'b1, 1'b1, 5, 16'h0000, 64'hDEAD, 1'b1, "write_mask_zero");
        drive(1'b0, 1'b1, 1'b0, 5, 16'h0014, 64'h0, 1'b1, "after_mask_zero");

        // Gating
        drive(1'b0, 1'b0, 1'b1, 5, 16'h0004, 64'h1234, 1'b1, "gated_output");
        drive(1'b0, 1'b1, 1'b0, 5, 16'h0004, 64'h0, 1'b1, "gated_no_write");

        // Reset priority over a same-edge write
        drive(1'b1, 1'b1, 1'b1, 1, 16'hFFFF, 64'hFFFF, 1'b1, "rst_wr_pre");
        drive(1'b0, 1'b1, 1'b0, 1, 16'hFFFF, 64'h0, 1'b1, "rst_prio_set1");
        drive(1'b0, 1'b1, 1'b0, 5, 16'h0004, 64'h0, 1'b1, "rst_prio_set5");

        // Randomized traffic concentrated on a few sets so reads hit written data
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(3, 0))
                0:       m = 16'h0001 << $urandom_range(15, 0);
                1:       m = 16'($urandom);
                2:       m = (16'h0001 << $urandom_range(15, 0)) | (16'h0001 << $urandom_range(15, 0));
                default: m = ($urandom_range(7, 0) == 0) ? 16'h0000 : 16'($urandom);
            endcase
            s = ($urandom_range(7, 0) == 0) ? 63 : int'($urandom_range(7, 0));
            drive(($urandom_range(99, 0) == 0), ($urandom_range(7, 0) != 0), $urandom_range(1, 0) == 1,
                  s, m, {$urandom, $urandom}, 1'b1, "random");
        end

        drive(1'b0, 1'b0, 1'b0, 0, 16'h0000, 64'h0, 1'b0, "idle");
        @(negedge clk_in); #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending=%0d expected=0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cache_data_array
